// File: rtl/pwl_sched_pkg.sv
// Shared types and helpers for the channel ALU scheduler.
package pwl_sched_pkg;

    typedef enum logic [1:0] {
        OP_PHASE  = 2'd0,
        OP_SWEEP0 = 2'd1,
        OP_SWEEP1 = 2'd2,
        OP_OUT    = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } sched_state_t;

    localparam int NUM_OPS = 4;
    localparam int OP_W    = 2;

    // PHASE and OUT always run; sweep ops only on sweep frames with their enable bit set.
    function automatic logic op_allowed(input logic [1:0] op, input logic sweep_act,
                                        input logic [1:0] sweep_bits);
        logic ok;
        ok = 1'b1;
        if (op == OP_SWEEP0) begin
            ok = sweep_act & sweep_bits[0];
        end else if (op == OP_SWEEP1) begin
            ok = sweep_act & sweep_bits[1];
        end
        return ok;
    endfunction

endpackage

// File: rtl/pwl_channel_scheduler_if.sv
// ALU request/ack and CPU config-grant signals between the scheduler and its neighbours.
interface pwl_channel_scheduler_if #(
    parameter int NUM_CH = 4
) ();
    import pwl_sched_pkg::*;

    localparam int CH_W = $clog2(NUM_CH);

    logic            alu_req;
    alu_op_t         alu_op;
    logic [CH_W-1:0] alu_chan;
    logic            alu_ack;
    logic            cfg_req;
    logic [CH_W-1:0] cfg_chan;
    logic            cfg_gnt;

    modport master (
        output alu_req,
        output alu_op,
        output alu_chan,
        output cfg_gnt,
        input  alu_ack,
        input  cfg_req,
        input  cfg_chan
    );

    modport slave (
        input  alu_req,
        input  alu_op,
        input  alu_chan,
        input  cfg_gnt,
        output alu_ack,
        output cfg_req,
        output cfg_chan
    );

endinterface

// File: rtl/pwl_tick_gen.sv
// Frame tick generator with a per-frame sweep divider; both counters freeze while disabled.
module pwl_tick_gen
    import pwl_sched_pkg::*;
#(
    parameter int TICK_PERIOD = 64,
    parameter int SWEEP_DIV   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic frame_tick,
    output logic sweep_frame
);

    localparam int TW = $clog2(TICK_PERIOD);
    localparam int SW = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;

    logic [TW-1:0] tick_cnt_reg;
    logic [SW-1:0] sweep_cnt_reg;

    assign frame_tick  = enable && (tick_cnt_reg == TW'(TICK_PERIOD - 1));
    assign sweep_frame = (sweep_cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_reg  <= '0;
            sweep_cnt_reg <= '0;
        end else if (enable) begin
            if (frame_tick) begin
                tick_cnt_reg  <= '0;
                sweep_cnt_reg <= (sweep_cnt_reg == SW'(SWEEP_DIV - 1)) ? '0
                                                                       : sweep_cnt_reg + SW'(1);
            end else begin
                tick_cnt_reg <= tick_cnt_reg + TW'(1);
            end
        end
    end

endmodule

// File: rtl/pwl_channel_scheduler.sv
// Walks every enabled {channel, op} slot through the shared ALU once per frame and
// grants CPU config writes only when they cannot tear the channel being processed.
module pwl_channel_scheduler
    import pwl_sched_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TICK_PERIOD = 64,
    parameter int SWEEP_DIV   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       chan_en,
    input  logic [2*NUM_CH-1:0]     sweep_en,
    pwl_channel_scheduler_if.master bus,
    output logic                    sample_valid,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int NSLOT = NUM_CH * NUM_OPS;
    localparam int SL_W  = $clog2(NSLOT) + 1;   // cursor may point one past the last slot

    logic frame_tick;
    logic sweep_frame;

    pwl_tick_gen #(
        .TICK_PERIOD (TICK_PERIOD),
        .SWEEP_DIV   (SWEEP_DIV)
    ) u_tick_gen (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .sweep_frame (sweep_frame)
    );

    sched_state_t    state_reg,     state_next;
    logic [SL_W-1:0] cursor_reg,    cursor_next;
    logic            sweep_act_reg, sweep_act_next;
    logic            alu_req_reg,   alu_req_next;
    alu_op_t         alu_op_reg,    alu_op_next;
    logic [CH_W-1:0] alu_chan_reg,  alu_chan_next;
    logic            overrun_reg;
    logic            gnt_prev_reg;

    // Slot index is {chan, op}, so ascending index gives the required issue order.
    logic [NSLOT-1:0] slot_ok;
    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            for (gj = 0; gj < NUM_OPS; gj++) begin : g_op
                assign slot_ok[gi*NUM_OPS + gj] = chan_en[gi] &&
                    op_allowed(2'(gj), sweep_act_reg, sweep_en[2*gi +: 2]);
            end
        end
    endgenerate

    logic            found;
    logic [SL_W-1:0] found_idx;

    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int k = NSLOT - 1; k >= 0; k--) begin
            if (slot_ok[k] && (SL_W'(k) >= cursor_reg)) begin
                found     = 1'b1;
                found_idx = SL_W'(k);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cursor_next    = cursor_reg;
        sweep_act_next = sweep_act_reg;
        alu_req_next   = alu_req_reg;
        alu_op_next    = alu_op_reg;
        alu_chan_next  = alu_chan_reg;
        case (state_reg)
            S_IDLE: begin
                if (frame_tick) begin
                    state_next     = S_ISSUE;
                    cursor_next    = '0;
                    sweep_act_next = sweep_frame;
                end
            end
            S_ISSUE: begin
                if (!enable) begin
                    state_next = S_IDLE;
                end else if (found) begin
                    state_next    = S_WAIT;
                    alu_req_next  = 1'b1;
                    alu_op_next   = alu_op_t'(found_idx[OP_W-1:0]);
                    alu_chan_next = found_idx[OP_W +: CH_W];
                    cursor_next   = found_idx + SL_W'(1);
                end else begin
                    state_next = S_DONE;
                end
            end
            S_WAIT: begin
                if (bus.alu_ack) begin
                    alu_req_next = 1'b0;
                    if (!enable) begin
                        state_next = S_IDLE;
                    end else if (found) begin
                        state_next = S_ISSUE;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cursor_reg    <= '0;
            sweep_act_reg <= 1'b0;
            alu_req_reg   <= 1'b0;
            alu_op_reg    <= OP_PHASE;
            alu_chan_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cursor_reg    <= cursor_next;
            sweep_act_reg <= sweep_act_next;
            alu_req_reg   <= alu_req_next;
            alu_op_reg    <= alu_op_next;
            alu_chan_reg  <= alu_chan_next;
        end
    end

    // A tick that finds the frame still busy is dropped, not queued; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_reg <= 1'b0;
        end else if (frame_tick && (state_reg != S_IDLE)) begin
            overrun_reg <= 1'b1;
        end else if (overrun_clr) begin
            overrun_reg <= 1'b0;
        end
    end

    logic cfg_safe;
    logic cfg_gnt;

    assign cfg_safe = (state_reg == S_IDLE) || (state_reg == S_DONE) ||
                      (alu_req_reg && (bus.cfg_chan != alu_chan_reg));
    assign cfg_gnt  = bus.cfg_req && !gnt_prev_reg && cfg_safe;

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_prev_reg <= 1'b0;
        end else begin
            gnt_prev_reg <= cfg_gnt;
        end
    end

    assign bus.alu_req  = alu_req_reg;
    assign bus.alu_op   = alu_op_reg;
    assign bus.alu_chan = alu_chan_reg;
    assign bus.cfg_gnt  = cfg_gnt;
    assign sample_valid = (state_reg == S_DONE);
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_pwl_channel_scheduler.sv
// Directed bench for the channel scheduler: ALU responder model, op log, hand-computed timings.
module tb_pwl_channel_scheduler;
    import pwl_sched_pkg::*;

    localparam int NUM_CH      = 4;
    localparam int TICK_PERIOD = 64;
    localparam int SWEEP_DIV   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [3:0] chan_en = 4'h0;
    logic [7:0] sweep_en = 8'h00;
    logic       sample_valid;
    logic       overrun;

    pwl_channel_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

    pwl_channel_scheduler #(
        .NUM_CH      (NUM_CH),
        .TICK_PERIOD (TICK_PERIOD),
        .SWEEP_DIV   (SWEEP_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .chan_en      (chan_en),
        .sweep_en     (sweep_en),
        .bus          (bus),
        .sample_valid (sample_valid),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: ack pulses once alu_req has been high for ack_delay cycles.
    int ack_delay = 3;
    int ack_cnt   = 0;
    initial begin
        bus.alu_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !bus.alu_req || bus.alu_ack) begin
                bus.alu_ack = 1'b0;
                ack_cnt     = 0;
            end else if (ack_cnt >= ack_delay - 1) begin
                bus.alu_ack = 1'b1;
                ack_cnt     = 0;
            end else begin
                ack_cnt++;
            end
        end
    end

    logic [3:0] op_log[$];
    int         sv_count = 0;
    logic       req_q = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.alu_req && !req_q) begin
                op_log.push_back({bus.alu_chan, bus.alu_op});
                $display("[%0d] alu issue ch%0d %s", cyc, bus.alu_chan, bus.alu_op.name());
            end
            req_q = bus.alu_req;
            if (sample_valid) begin
                sv_count++;
                $display("[%0d] sample_valid", cyc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int get_op(input int idx);
        if (idx < op_log.size()) return int'(op_log[idx]);
        return -1;
    endfunction

    task automatic start_run(input logic [3:0] ce, input logic [7:0] se, input int dly,
                             output int c0);
        rst          = 1'b1;
        enable       = 1'b0;
        bus.cfg_req  = 1'b0;
        bus.cfg_chan = '0;
        overrun_clr  = 1'b0;
        chan_en      = ce;
        sweep_en     = se;
        ack_delay    = dly;
        repeat (2) step();
        rst    = 1'b0;
        enable = 1'b1;
        c0     = cyc;
    endtask

    // Returns cycles since c0 at which sv_count first exceeds base, or -1 on timeout.
    task automatic wait_sv(input int base, input int limit, input int c0, output int k);
        k = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (sv_count > base) begin
                k = cyc - c0;
                break;
            end
        end
    endtask

    task automatic wait_req(input int limit, input int chan, input int op, output int ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (bus.alu_req && (chan < 0 || int'(bus.alu_chan) == chan) &&
                (op < 0 || int'(bus.alu_op) == op)) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        int c0, c1, k, b, sb, ok, ack_k, gnt_k;
        int exp1[8];
        int exp2[4];

        bus.cfg_req  = 1'b0;
        bus.cfg_chan = '0;

        // Reset state
        repeat (3) step();
        check_eq("rst_alu_req", bus.alu_req, 0);
        check_eq("rst_alu_op", bus.alu_op, 0);
        check_eq("rst_alu_chan", bus.alu_chan, 0);
        check_eq("rst_cfg_gnt", bus.cfg_gnt, 0);
        check_eq("rst_sample_valid", sample_valid, 0);
        check_eq("rst_overrun", overrun, 0);

        // 1: all channels, no sweep, 3-cycle ALU
        start_run(4'hF, 8'h00, 3, c0);
        b = op_log.size(); sb = sv_count;
        wait_sv(sb, 200, c0, k);
        check_eq("t1_sv_latency", k, 96);
        check_eq("t1_op_count", op_log.size() - b, 8);
        exp1 = '{0, 3, 4, 7, 8, 11, 12, 15};
        for (int i = 0; i < 8; i++) check_eq($sformatf("t1_op%0d", i), get_op(b + i), exp1[i]);
        repeat (25) step();
        check_eq("t1_sv_once", sv_count - sb, 1);

        // 2: sweep frame on ch1, then a plain frame
        start_run(4'b0010, 8'b0000_1100, 3, c0);
        b = op_log.size(); sb = sv_count;
        wait_sv(sb, 200, c0, k);
        check_eq("t2_sv_latency_f1", k, 80);
        check_eq("t2_op_count_f1", op_log.size() - b, 4);
        exp2 = '{4, 5, 6, 7};
        for (int i = 0; i < 4; i++) check_eq($sformatf("t2_f1_op%0d", i), get_op(b + i), exp2[i]);
        b = op_log.size();
        wait_sv(sb + 1, 200, c0, k);
        check_eq("t2_sv_latency_f2", k, 136);
        check_eq("t2_op_count_f2", op_log.size() - b, 2);
        check_eq("t2_f2_op0", get_op(b), 4);
        check_eq("t2_f2_op1", get_op(b + 1), 7);

        // 3: cfg write to the busy channel is deferred, other channel granted at once
        start_run(4'b0111, 8'h00, 6, c0);
        wait_req(200, 2, 0, ok);
        check_eq("t3_reach_ch2", ok, 1);
        bus.cfg_req  = 1'b1;
        bus.cfg_chan = 2'd2;
        ack_k = -100; gnt_k = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.alu_req && bus.alu_chan == 2'd2 && bus.alu_op == OP_OUT && bus.alu_ack)
                ack_k = cyc;
            if (bus.cfg_gnt) begin
                gnt_k = cyc;
                $display("[%0d] cfg grant ch%0d", cyc, bus.cfg_chan);
                break;
            end
        end
        check_eq("t3_gnt_after_out_ack", gnt_k - ack_k, 1);
        step();
        check_eq("t3_gnt_one_cycle", bus.cfg_gnt, 0);
        bus.cfg_req = 1'b0;
        wait_req(200, 2, -1, ok);
        check_eq("t3_reach_ch2_f2", ok, 1);
        bus.cfg_req  = 1'b1;
        bus.cfg_chan = 2'd0;
        #1;
        check_eq("t3_gnt_other_chan", bus.cfg_gnt, 1);
        step();
        bus.cfg_req = 1'b0;

        // 4: slow ALU overruns the frame; set beats clear, later clear works
        start_run(4'hF, 8'h00, 20, c0);
        b = op_log.size(); sb = sv_count;
        while (cyc - c0 < 127) step();
        check_eq("t4_overrun_pre", overrun, 0);
        overrun_clr = 1'b1;
        step();
        check_eq("t4_overrun_set_wins", overrun, 1);
        overrun_clr = 1'b0;
        wait_sv(sb, 300, c0, k);
        check_eq("t4_sv_latency", k, 232);
        check_eq("t4_op_count", op_log.size() - b, 8);
        check_eq("t4_overrun_sticky", overrun, 1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check_eq("t4_overrun_cleared", overrun, 0);

        // 5: no channels enabled
        start_run(4'h0, 8'h00, 3, c0);
        b = op_log.size(); sb = sv_count;
        wait_sv(sb, 200, c0, k);
        check_eq("t5_sv_latency_f1", k, 65);
        wait_sv(sb + 1, 200, c0, k);
        check_eq("t5_sv_latency_f2", k, 129);
        check_eq("t5_no_alu_req", op_log.size() - b, 0);

        // 6a: reset during WAIT
        start_run(4'hF, 8'h00, 10, c0);
        wait_req(200, -1, -1, ok);
        check_eq("t6a_in_wait", ok, 1);
        rst = 1'b1;
        step();
        check_eq("t6a_req_dropped", bus.alu_req, 0);
        check_eq("t6a_no_sv", sample_valid, 0);

        // 6b: enable dropped during WAIT
        start_run(4'hF, 8'h00, 10, c0);
        wait_req(200, -1, -1, ok);
        check_eq("t6b_req_at", cyc - c0, 65);
        enable = 1'b0;
        b = op_log.size(); sb = sv_count;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.alu_ack) begin
                ok = int'(bus.alu_req);
                break;
            end
        end
        check_eq("t6b_req_held_to_ack", ok, 1);
        step();
        check_eq("t6b_req_after_ack", bus.alu_req, 0);
        repeat (40) step();
        check_eq("t6b_no_new_ops", op_log.size() - b, 0);
        check_eq("t6b_no_sv", sv_count - sb, 0);
        enable = 1'b1;
        c1 = cyc;
        wait_req(200, -1, -1, ok);
        check_eq("t6b_counter_held", ok ? (cyc - c1) : -1, 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
